// File: rtl/prover_fold_v.sv
// Folds a snapshotted layer-value array in half with one sumcheck challenge:
// out[j] = v[2j] + tau*(v[2j+1]-v[2j]) mod F_Q, one pair per enabled cycle through a shared multiplier.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFFFFFFFFFFFFFF
`endif

module prover_fold_v #(
    parameter int nInBits  = 4,
    parameter int plstages = 2
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic                restart,
    input  logic [`F_NBITS-1:0] tau,
    input  logic [`F_NBITS-1:0] v_in  [1 << nInBits],
    output logic                ready,
    output logic                ready_pulse,
    output logic [`F_NBITS-1:0] v_out [(1 << nInBits) / 2]
);

    localparam int W  = `F_NBITS;
    localparam int NG = 1 << nInBits;
    localparam int NP = NG / 2;
    localparam int CW = nInBits;
    localparam int JW = (nInBits > 1) ? nInBits - 1 : 1;
    localparam logic [W-1:0] Q = `F_Q;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   v_snap_q [NG];
    logic [W-1:0]   tau_q;
    logic [CW-1:0]  cnt_q;
    logic           ready_q, ready_pulse_q;
    logic [W-1:0]   v_out_q [NP];

    logic           s0_valid_q;
    logic [W-1:0]   s0_d_q, s0_v0_q;
    logic [JW-1:0]  s0_j_q;

    logic [JW-1:0]  issue_j;
    logic [W-1:0]   iv0, iv1, idiff;
    logic [W-1:0]   mul_p;
    logic           fin_valid;
    logic [W-1:0]   fin_prod, fin_v0;
    logic [JW-1:0]  fin_j;
    logic [W:0]     fin_sum;
    logic [W-1:0]   wr_val;
    logic           issue, wr, done;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (en) begin
            if (restart)                        state_d = RUN;
            else if (state_q == RUN && done)    state_d = IDLE;
        end
    end

    // ---------------- FSM: outputs / control ----------------
    // Restart suppresses both issue and the final-stage write so an aborted fold never lands.
    always_comb begin
        issue = (state_q == RUN) && (cnt_q < CW'(NP)) && !restart;
        wr    = fin_valid && !restart;
        done  = wr && (fin_j == JW'(NP - 1));
    end

    // ---------------- issue stage: pair select and modular difference ----------------
    always_comb begin
        issue_j = cnt_q[JW-1:0];
        iv0     = v_snap_q[{issue_j, 1'b0}];
        iv1     = v_snap_q[{issue_j, 1'b1}];
        idiff   = iv1 - iv0;
        if (iv1 < iv0) idiff = idiff + Q;
    end

    always_comb begin
        mul_p = W'(({{W{1'b0}}, s0_d_q} * {{W{1'b0}}, tau_q}) % {{W{1'b0}}, Q});
    end

    // ---------------- multiplier pipeline ----------------
    generate
        if (plstages == 0) begin : g_nopipe
            assign fin_valid = s0_valid_q;
            assign fin_prod  = mul_p;
            assign fin_v0    = s0_v0_q;
            assign fin_j     = s0_j_q;
        end else begin : g_pipe
            logic           pv_q  [plstages];
            logic [W-1:0]   pp_q  [plstages];
            logic [W-1:0]   pv0_q [plstages];
            logic [JW-1:0]  pj_q  [plstages];

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    for (int unsigned k = 0; k < plstages; k++) begin
                        pv_q[k]  <= 1'b0;
                        pp_q[k]  <= '0;
                        pv0_q[k] <= '0;
                        pj_q[k]  <= '0;
                    end
                end else if (en) begin
                    pv_q[0]  <= s0_valid_q && !restart;
                    pp_q[0]  <= mul_p;
                    pv0_q[0] <= s0_v0_q;
                    pj_q[0]  <= s0_j_q;
                    for (int unsigned k = 1; k < plstages; k++) begin
                        pv_q[k]  <= pv_q[k-1] && !restart;
                        pp_q[k]  <= pp_q[k-1];
                        pv0_q[k] <= pv0_q[k-1];
                        pj_q[k]  <= pj_q[k-1];
                    end
                end
            end

            assign fin_valid = pv_q[plstages-1];
            assign fin_prod  = pp_q[plstages-1];
            assign fin_v0    = pv0_q[plstages-1];
            assign fin_j     = pj_q[plstages-1];
        end
    endgenerate

    // ---------------- final stage: add and conditional subtract ----------------
    always_comb begin
        fin_sum = {1'b0, fin_v0} + {1'b0, fin_prod};
        if (fin_sum >= {1'b0, Q}) wr_val = W'(fin_sum - {1'b0, Q});
        else                      wr_val = W'(fin_sum);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int unsigned i = 0; i < NG; i++) v_snap_q[i] <= '0;
            for (int unsigned i = 0; i < NP; i++) v_out_q[i]  <= '0;
            tau_q      <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            s0_valid_q <= 1'b0;
            s0_d_q     <= '0;
            s0_v0_q    <= '0;
            s0_j_q     <= '0;
        end else if (en) begin
            if (restart) begin
                for (int unsigned i = 0; i < NG; i++) v_snap_q[i] <= v_in[i];
                tau_q      <= tau;
                cnt_q      <= '0;
                ready_q    <= 1'b0;
                s0_valid_q <= 1'b0;
            end else begin
                if (issue) cnt_q <= cnt_q + 1'b1;
                s0_valid_q <= issue;
                s0_d_q     <= idiff;
                s0_v0_q    <= iv0;
                s0_j_q     <= issue_j;
                if (wr)   v_out_q[fin_j] <= wr_val;
                if (done) ready_q <= 1'b1;
            end
        end
    end

    // Pulse is not held by en: it always clears on the following edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) ready_pulse_q <= 1'b0;
        else       ready_pulse_q <= en && done;
    end

    assign ready       = ready_q;
    assign ready_pulse = ready_pulse_q;
    assign v_out       = v_out_q;

endmodule

// File: tb/tb_prover_fold_v.sv
// Randomized self-checking bench for prover_fold_v against a plain mod-Q arithmetic model.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFFFFFFFFFFFFFF
`endif

module tb_prover_fold_v;

    localparam int NIB = 4;
    localparam int PLS = 2;
    localparam int W   = `F_NBITS;
    localparam int NG  = 1 << NIB;
    localparam int NP  = NG / 2;
    localparam int LAT = NP + PLS + 1;
    localparam logic [W-1:0] Q = `F_Q;

    logic          clk = 1'b0;
    logic          rstb;
    logic          en;
    logic          restart;
    logic [W-1:0]  tau;
    logic [W-1:0]  vin  [NG];
    logic          ready;
    logic          ready_pulse;
    logic [W-1:0]  vout [NP];

    logic [W-1:0]  ref_v [NG];
    logic [W-1:0]  ref_tau;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt;
    int lat;

    prover_fold_v #(.nInBits(NIB), .plstages(PLS)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en),
        .restart     (restart),
        .tau         (tau),
        .v_in        (vin),
        .ready       (ready),
        .ready_pulse (ready_pulse),
        .v_out       (vout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // out = a + t*(b - a) in the integers, reduced mod Q (wide arithmetic, no pipeline notion).
    function automatic logic [W-1:0] fold_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] t);
        logic [127:0] aa, bb, tt, r;
        aa = 128'(a); bb = 128'(b); tt = 128'(t);
        r  = (aa + tt * ((bb + 128'(Q) - aa) % 128'(Q))) % 128'(Q);
        return W'(r);
    endfunction

    function automatic logic [W-1:0] rnd_fe();
        logic [63:0] r;
        int unsigned sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return '0;
        if (sel == 1) return Q - 1'b1;
        r = {$urandom(), $urandom()};
        return W'(r % 64'(Q));
    endfunction

    task automatic capture_ref();
        for (int i = 0; i < NG; i++) ref_v[i] = vin[i];
        ref_tau = tau;
    endtask

    task automatic check_vout(input string tag);
        for (int j = 0; j < NP; j++)
            chk($sformatf("%s v_out[%0d]", tag, j), 64'(vout[j]),
                64'(fold_ref(ref_v[2*j], ref_v[2*j+1], ref_tau)));
    endtask

    // Drives one restart edge (edge 0); vin/tau must already hold the operands.
    task automatic start_fold();
        @(negedge clk);
        en = 1'b1; restart = 1'b1;
        capture_ref();
        @(posedge clk); #1;
        restart = 1'b0;
        if (ready_pulse) pulse_cnt++;
    endtask

    // Counts edges after edge 0 until ready; en is low for edges stall_at+1 .. stall_at+stall_len.
    task automatic wait_ready(input int stall_at, input int stall_len, output int n);
        n = 0;
        while (n < 200) begin
            en = !(n >= stall_at && n < stall_at + stall_len);
            @(posedge clk); #1;
            n++;
            if (ready_pulse) pulse_cnt++;
            if (ready) break;
        end
        en = 1'b1;
        if (!ready) chk("ready timeout", 64'(ready), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ready_pulse) pulse_cnt++;
        end
    endtask

    initial begin
        rstb = 1'b0; en = 1'b0; restart = 1'b0; tau = '0;
        for (int i = 0; i < NG; i++) vin[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset ready_pulse", 64'(ready_pulse), 64'd0);
        chk("reset v_out[0]", 64'(vout[0]), 64'd0);
        chk("reset v_out[last]", 64'(vout[NP-1]), 64'd0);
        @(negedge clk); rstb = 1'b1;

        // Basic fold
        for (int i = 0; i < NG; i++) vin[i] = W'(i);
        tau = W'(2);
        pulse_cnt = 0;
        start_fold();
        wait_ready(-1, 0, lat);
        chk("basic latency", 64'(lat), 64'(LAT));
        chk("basic ready_pulse at rise", 64'(ready_pulse), 64'd1);
        idle_cycles(4);
        chk("basic pulse count", 64'(pulse_cnt), 64'd1);
        chk("basic v_out[7] const", 64'(vout[7]), 64'd16);
        check_vout("basic");

        // Endpoints tau=0 and tau=1; also checks ready drops on the restart edge
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < NG; i++) vin[i] = rnd_fe();
            tau = W'(t);
            pulse_cnt = 0;
            start_fold();
            chk($sformatf("tau%0d ready drop", t), 64'(ready), 64'd0);
            wait_ready(-1, 0, lat);
            chk($sformatf("tau%0d latency", t), 64'(lat), 64'(LAT));
            idle_cycles(2);
            chk($sformatf("tau%0d pulse count", t), 64'(pulse_cnt), 64'd1);
            chk($sformatf("tau%0d v_out[0] endpoint", t), 64'(vout[0]),
                64'(t == 0 ? ref_v[0] : ref_v[1]));
            check_vout($sformatf("tau%0d", t));
        end

        // Wraparound cases
        vin[0] = W'(5); vin[1] = W'(3); tau = W'(2);
        start_fold(); wait_ready(-1, 0, lat);
        chk("wrap1 v_out[0]", 64'(vout[0]), 64'd1);
        vin[0] = Q - 1'b1; vin[1] = '0; tau = Q - 1'b1;
        start_fold(); wait_ready(-1, 0, lat);
        chk("wrap2 v_out[0]", 64'(vout[0]), 64'(Q - 2'd2));
        check_vout("wrap2");

        // Stall mid-RUN
        for (int i = 0; i < NG; i++) vin[i] = W'(i);
        tau = W'(2);
        pulse_cnt = 0;
        start_fold();
        wait_ready(3, 5, lat);
        chk("stall latency", 64'(lat), 64'(LAT + 5));
        idle_cycles(3);
        chk("stall pulse count", 64'(pulse_cnt), 64'd1);
        check_vout("stall");

        // Abort: restart at cycle 4 with new operands
        pulse_cnt = 0;
        start_fold();
        idle_cycles(3);
        for (int i = 0; i < NG; i++) vin[i] = W'(100 + i);
        tau = W'(1);
        start_fold();
        wait_ready(-1, 0, lat);
        chk("abort latency", 64'(lat), 64'(LAT));
        idle_cycles(3);
        chk("abort pulse count", 64'(pulse_cnt), 64'd1);
        for (int j = 0; j < NP; j++)
            chk($sformatf("abort v_out[%0d]", j), 64'(vout[j]), 64'(101 + 2*j));

        // Reset mid-RUN
        for (int i = 0; i < NG; i++) vin[i] = rnd_fe();
        tau = rnd_fe();
        pulse_cnt = 0;
        start_fold();
        idle_cycles(5);
        #2 rstb = 1'b0;
        #1;
        chk("rst ready", 64'(ready), 64'd0);
        chk("rst ready_pulse", 64'(ready_pulse), 64'd0);
        begin
            int nz = 0;
            for (int j = 0; j < NP; j++) if (vout[j] != '0) nz++;
            chk("rst v_out nonzero count", 64'(nz), 64'd0);
        end
        @(negedge clk); rstb = 1'b1;
        pulse_cnt = 0;
        idle_cycles(20);
        chk("rst no later pulse", 64'(pulse_cnt), 64'd0);
        chk("rst ready stays low", 64'(ready), 64'd0);

        // Randomized folds with stalls; inputs scrambled after the snapshot
        for (int r = 0; r < 20; r++) begin
            int sa, sl;
            for (int i = 0; i < NG; i++) vin[i] = rnd_fe();
            tau = rnd_fe();
            sa = int'($urandom_range(0, 8));
            sl = int'($urandom_range(0, 4));
            pulse_cnt = 0;
            start_fold();
            for (int i = 0; i < NG; i++) vin[i] = rnd_fe();
            tau = rnd_fe();
            wait_ready(sa, sl, lat);
            chk($sformatf("rnd%0d latency", r), 64'(lat), 64'(LAT + sl));
            idle_cycles(2);
            chk($sformatf("rnd%0d pulse count", r), 64'(pulse_cnt), 64'd1);
            check_vout($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prover_fold_v.md
# prover_fold_v

Folds a shuffled layer-value array in half with one sumcheck challenge: out[j] = v_in[2j] + tau·(v_in[2j+1] − v_in[2j]) mod `F_Q. Sits directly downstream of prover_shuffle_v and consumes its v_out after each round. The folded array is then re-presented, via the round controller, to the next shuffle/round. One pipelined field multiplier is time-shared over all pairs.

## Interface
- nInBits, default 4: log2 of input array length; ngates = 1 << nInBits, npairs = ngates/2; legal range ≥ 1.
- plstages, default 2: multiplier pipeline depth in registers; legal range ≥ 0.
- Clock/reset: one clock; reset is asynchronous and active-low.
- clk  input  1  clock, all state on posedge.
- rstb  input  1  asynchronous active-low reset.
- en  input  1  advance enable; block state moves only on cycles with en=1.
- restart  input  1  start a new fold; honored only when en=1.
- tau  input  `F_NBITS  challenge, fully reduced (< `F_Q).
- v_in  input  `F_NBITS × ngates  unpacked array from prover_shuffle_v, each element < `F_Q.
- ready  output  1  v_out holds a completed fold.
- ready_pulse  output  1  one-cycle strobe at completion.
- v_out  output  `F_NBITS × npairs  registered folded array.

## Operation
- States: IDLE, RUN. Reset: IDLE, ready=0, ready_pulse=0, all v_out=0, pair counter 0.
- Start: en=1 and restart=1 at an edge → snapshot v_in and tau into internal registers, ready←0, counter←0, state RUN. Later changes to v_in/tau are ignored.
- RUN, per en=1 cycle: issue pair j=counter: d = v1−v0 if v1≥v0 else v1−v0+`F_Q (registered); multiply d·tau mod `F_Q through plstages registers; final stage s = v0+prod, subtract `F_Q if s ≥ `F_Q, write v_out[j]. v0 and j travel alongside the pipe.
- Counter increments after each issue; issue stops after j = npairs−1; state returns to IDLE when the last write occurs.
- Completion: at the edge that writes v_out[npairs−1], ready←1 and ready_pulse←1; ready_pulse clears next en=1 cycle or next cycle, whichever comes first (it is always exactly one cycle wide).
- en=0: every register, including pipeline, counter, ready_pulse source state, holds. ready_pulse is still forced low after one cycle.
- Restart mid-RUN (en=1): abort; all in-flight pipeline entries are invalidated and never written; new snapshot taken; no ready_pulse for the aborted fold; entries of v_out already written by the aborted fold remain until overwritten.
- Restart in the same cycle as completion: restart wins; ready stays 0, no pulse.
- v_out entries are written only by the fold that issued them.
- All arithmetic is exact mod `F_Q; intermediate sum uses `F_NBITS+1 bits; product reduction is fully reduced (< `F_Q).

## Timing
- With en held 1, edge 0 samples restart; pair j is issued at edge j+1 and v_out[j] is written at edge j+plstages+2.
- Latency restart→ready: L = npairs + plstages + 1 cycles. Defaults: 8+2+1 = 11.
- Throughput: one pair per cycle; back-to-back folds require a restart after ready (no overlap).
- ready_pulse coincides with ready rising; the restart cycle drops ready on the same edge.
- Reset asserted at any time returns all outputs to reset values immediately.

## Test plan
- Basic: v_in[i]=i, tau=2, restart pulse, en=1 → after 11 cycles ready=1, single ready_pulse, v_out[j]=2j+2 (2,4,…,16).
- Endpoints: tau=0 → v_out[j]=v_in[2j]; tau=1 → v_out[j]=v_in[2j+1]; same 11-cycle latency.
- Wraparound: v_in[0]=5, v_in[1]=3, tau=2 → v_out[0]=1; v_in[0]=`F_Q−1, v_in[1]=0, tau=`F_Q−1 → v_out[0]=`F_Q−2.
- Stall: drop en for 5 cycles mid-RUN → ready rises at 16 cycles, results identical to basic; ready_pulse exactly one cycle.
- Abort: restart at cycle 4 with v_in[i]=100+i, tau=1 → one ready_pulse only, 11 cycles after second restart, v_out[j]=101+2j.
- Reset mid-RUN: rstb low at cycle 6 → ready=0, ready_pulse=0, v_out all 0 immediately; no later pulse without a new restart.
